// File: rtl/byte_ram_pkg.sv
// Shared access-mode encodings and lane-count helper for the byte-addressable data RAM.
package byte_ram_pkg;

    localparam logic [1:0] MODE_BYTE = 2'd0;
    localparam logic [1:0] MODE_HALF = 2'd1;
    localparam logic [1:0] MODE_WORD = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    // Number of byte lanes touched by an access; the reserved mode touches none.
    function automatic logic [2:0] lane_count(input logic [1:0] mode);
        logic [2:0] n;
        case (mode)
            MODE_BYTE: n = 3'd1;
            MODE_HALF: n = 3'd2;
            MODE_WORD: n = 3'd4;
            default:   n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/byte_ram.sv
// Little-endian byte/half/word data RAM over a fixed address window, one store and one load port.
// Latency: 1-cycle registered read (read-before-write); no backpressure, accepts a store and a load every cycle.
module byte_ram
    import byte_ram_pkg::*;
#(
    parameter int unsigned START_ADDRESS = 1024,
    parameter int unsigned STOP_ADDRESS  = START_ADDRESS + 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wr_addr,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_mode,
    input  logic [31:0] rd_addr,
    input  logic        rd_en,
    input  logic [1:0]  rd_mode,
    output logic [31:0] rd_data
);

    localparam int unsigned DEPTH   = STOP_ADDRESS - START_ADDRESS + 1;
    localparam int          IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] START_A = 32'(START_ADDRESS);
    localparam logic [31:0] STOP_A  = 32'(STOP_ADDRESS);

    // Power-up contents are zero; reset deliberately leaves the array alone.
    logic [7:0]      mem_q [DEPTH] = '{default: 8'h00};

    logic [31:0]     wr_lane_addr [4];
    logic [31:0]     rd_lane_addr [4];
    logic [IDXW-1:0] wr_idx [4];
    logic [IDXW-1:0] rd_idx [4];
    logic [3:0]      wr_in_win;
    logic [3:0]      rd_in_win;
    logic [3:0]      wr_lane_en;
    logic [2:0]      wr_n;
    logic [2:0]      rd_n;
    logic [31:0]     rd_data_d;
    logic [31:0]     rd_data_q;

    always_comb begin
        wr_n = lane_count(wr_mode);
        rd_n = lane_count(rd_mode);
        for (int i = 0; i < 4; i++) begin
            wr_lane_addr[i] = wr_addr + 32'(i);
            rd_lane_addr[i] = rd_addr + 32'(i);
            // Window check happens before the index is used, so truncation is safe.
            wr_in_win[i]    = (wr_lane_addr[i] >= START_A) && (wr_lane_addr[i] <= STOP_A);
            rd_in_win[i]    = (rd_lane_addr[i] >= START_A) && (rd_lane_addr[i] <= STOP_A);
            wr_idx[i]       = IDXW'(wr_lane_addr[i] - START_A);
            rd_idx[i]       = IDXW'(rd_lane_addr[i] - START_A);
            wr_lane_en[i]   = wr_en && !reset && wr_in_win[i] && (3'(i) < wr_n);
        end
    end

    always_comb begin
        rd_data_d = '0;
        for (int i = 0; i < 4; i++) begin
            if (rd_in_win[i] && (3'(i) < rd_n)) begin
                rd_data_d[8*i +: 8] = mem_q[rd_idx[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_lane_en[i]) begin
                mem_q[wr_idx[i]] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_byte_ram.sv
// Bench for byte_ram: directed vector table, reset/retention sequence, random traffic vs. a byte-array model.
module tb_byte_ram;

    localparam int START = 1024;
    localparam int STOP  = 1055;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] wr_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [1:0]  wr_mode;
    logic [31:0] rd_addr;
    logic        rd_en;
    logic [1:0]  rd_mode;
    logic [31:0] rd_data;

    always #5 clk = ~clk;

    byte_ram #(.START_ADDRESS(START), .STOP_ADDRESS(STOP)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_addr (wr_addr),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .wr_mode (wr_mode),
        .rd_addr (rd_addr),
        .rd_en   (rd_en),
        .rd_mode (rd_mode),
        .rd_data (rd_data)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  model_mem [STOP-START+1];
    logic [31:0] model_rd;

    function automatic int nbytes(input logic [1:0] m);
        return (m == 2'd0) ? 1 : (m == 2'd1) ? 2 : (m == 2'd2) ? 4 : 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] m);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < nbytes(m); i++) begin
            longint la = longint'(a) + i;
            if (la >= START && la <= STOP) r = r | (32'(model_mem[la - START]) << (8 * i));
        end
        return r;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [1:0] m, input logic [31:0] d);
        for (int i = 0; i < nbytes(m); i++) begin
            longint la = longint'(a) + i;
            if (la >= START && la <= STOP) model_mem[la - START] = d[8*i +: 8];
        end
    endtask

    // One clock cycle of stimulus; the model is advanced with read-before-write semantics.
    task automatic step(input logic rs, input logic we, input logic [1:0] wm, input logic [31:0] wa,
                        input logic [31:0] wd, input logic re, input logic [1:0] rm, input logic [31:0] ra);
        @(negedge clk);
        reset = rs; wr_en = we; wr_mode = wm; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_mode = rm; rd_addr = ra;
        @(posedge clk);
        if (rs) begin
            model_rd = 32'h0;
        end else begin
            if (re) model_rd = model_load(ra, rm);
            if (we) model_store(wa, wm, wd);
        end
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] exp);
        checks++;
        if (rd_data !== exp) begin
            errors++;
            $display("FAIL %s: rd_data=%08h expected %08h", name, rd_data, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  wm;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        re;
        logic [1:0]  rm;
        logic [31:0] ra;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [$];

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_mode = 2'd0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_mode = 2'd0; rd_addr = '0;
        for (int i = 0; i <= STOP - START; i++) model_mem[i] = 8'h00;
        model_rd = 32'h0;

        //           we    wm    wa     wd            re    rm    ra     expected rd_data
        tbl.push_back('{1'b1, 2'd0, 32'd1027, 32'h000000A5, 1'b0, 2'd0, 32'd0,    32'h00000000});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd0, 32'd1027, 32'h000000A5});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd2, 32'd1024, 32'hA5000000});
        tbl.push_back('{1'b1, 2'd1, 32'd1030, 32'h0000BEEF, 1'b0, 2'd0, 32'd0,    32'hA5000000});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd0, 32'd1030, 32'h000000EF});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd0, 32'd1031, 32'h000000BE});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd1, 32'd1030, 32'h0000BEEF});
        tbl.push_back('{1'b1, 2'd2, 32'd1024, 32'h12345678, 1'b0, 2'd0, 32'd0,    32'h0000BEEF});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd2, 32'd1024, 32'h12345678});
        tbl.push_back('{1'b1, 2'd2, 32'd1054, 32'hDEADBEEF, 1'b0, 2'd0, 32'd0,    32'h12345678});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd2, 32'd1054, 32'h0000BEEF});
        tbl.push_back('{1'b1, 2'd0, 32'd1040, 32'h00000022, 1'b0, 2'd0, 32'd0,    32'h0000BEEF});
        tbl.push_back('{1'b1, 2'd0, 32'd1040, 32'h00000011, 1'b1, 2'd0, 32'd1040, 32'h00000022});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd0, 32'd1040, 32'h00000011});
        tbl.push_back('{1'b1, 2'd3, 32'd1032, 32'hFFFFFFFF, 1'b0, 2'd0, 32'd0,    32'h00000011});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd2, 32'd1032, 32'h00000000});
        tbl.push_back('{1'b1, 2'd2, 32'd1000, 32'hFFFFFFFF, 1'b0, 2'd0, 32'd0,    32'h00000000});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd2, 32'd1022, 32'h56780000});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd2, 32'd1024, 32'h12345678});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd3, 32'd1024, 32'h00000000});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd1, 32'd1024, 32'h00005678});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd2, 32'd2000, 32'h00000000});
        tbl.push_back('{1'b1, 2'd1, 32'd1055, 32'h0000CAFE, 1'b0, 2'd0, 32'd0,    32'h00000000});
        tbl.push_back('{1'b0, 2'd0, 32'd0,    32'h0,        1'b1, 2'd1, 32'd1054, 32'h0000FEEF});

        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0);
        step(1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0);
        check("reset", 32'h0);

        for (int a = START; a <= STOP; a++) begin
            step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd0, 32'(a));
            check($sformatf("powerup@%0d", a), 32'h0);
        end

        for (int v = 0; v < tbl.size(); v++) begin
            step(1'b0, tbl[v].we, tbl[v].wm, tbl[v].wa, tbl[v].wd, tbl[v].re, tbl[v].rm, tbl[v].ra);
            check($sformatf("vec%0d", v), tbl[v].exp);
        end

        // Reset clears rd_data, blocks the concurrent store, and leaves memory intact.
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd2, 32'd1024);
        check("pre_reset", 32'h12345678);
        step(1'b1, 1'b1, 2'd2, 32'd1024, 32'h0, 1'b1, 2'd2, 32'd1024);
        check("reset_clears", 32'h0);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 2'd0, 32'd0);
        check("hold_after_reset", 32'h0);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd2, 32'd1024);
        check("retained", 32'h12345678);
        step(1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 1'b1, 2'd1, 32'd1040);
        check("retained_1040", 32'h00000011);

        for (int n = 0; n < 400; n++) begin
            logic        rs;
            logic [31:0] wa;
            logic [31:0] ra;
            rs = ($urandom_range(0, 39) == 0);
            wa = 32'($urandom_range(START - 6, STOP + 6));
            ra = ($urandom_range(0, 3) == 0) ? wa : 32'($urandom_range(START - 6, STOP + 6));
            step(rs, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), wa, $urandom,
                 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), ra);
            check($sformatf("rand%0d", n), model_rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
